lab08_dp_arbiter: RTL and testbench
===================================

Name: lab08_dp_arbiter

Overview:
- Round-robin arbiter sharing one Lab08 streaming datapath between two requesters.
- The datapath has in_valid/in_data1/in_data2 inputs and out_valid/out_data outputs, with in-order results and no stall capability.
- The arbiter issues one operand pair per cycle to the datapath. It tags each issue with the requester ID in an internal tag FIFO, then routes each returned result to the owning requester.
- It sits between the two client blocks and the datapath instance; all three share clk/rst_n.

Parameters:
- DW_IN, 3, width of each operand (in_data1/in_data2).
- DW_OUT, 8, width of datapath result.
- DEPTH, 4, max in-flight operations (tag FIFO depth, power of two, >=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req0_data1  input  DW_IN  requester 0 operand 1.
- req0_data2  input  DW_IN  requester 0 operand 2.
- req1_valid, req1_ready, req1_data1, req1_data2: same as requester 0.
- dp_in_valid  output  1  drives datapath in_valid.
- dp_in_data1  output  DW_IN  drives datapath in_data1.
- dp_in_data2  output  DW_IN  drives datapath in_data2.
- dp_out_valid  input  1  datapath out_valid.
- dp_out_data  input  DW_OUT  datapath out_data.
- resp0_valid  output  1  result for requester 0.
- resp0_data  output  DW_OUT  result value for requester 0.
- resp1_valid, resp1_data: same as requester 0.
- inflight  output  $clog2(DEPTH+1)  number of issued, unreturned operations.
- orphan_err  output  1  sticky: result arrived with no tag outstanding.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, tag FIFO empty, inflight=0, orphan_err=0, last_grant=1 (requester 0 wins first contention). dp_in_data*/resp*_data are 0, not X.
- Grant (combinational, same cycle):
  - full = (inflight==DEPTH).
  - If full, no ready.
  - Else if exactly one reqN_valid, that reqN_ready=1.
  - Else if both valid, grant requester != last_grant.
  - reqN_ready never depends on anything but valids, last_grant and full.
- Handshake = reqN_valid & reqN_ready. On handshake:
  - Latch operands into dp_in_data1/2.
  - Set dp_in_valid=1 on the next cycle (issue latency 1).
  - Push ID N to tag FIFO.
  - last_grant<=N.
  - No handshake -> dp_in_valid=0, dp_in_data*=0.
- Back-to-back: one issue per cycle sustained while not full. With both valid continuously, grants alternate 0,1,0,1.
- Return: on dp_out_valid=1, pop head ID, register dp_out_data into respID_data and pulse respID_valid=1 for one cycle (return latency 1). Other resp outputs are 0 that cycle.
- Simultaneous push and pop: inflight unchanged. Full is evaluated on the pre-update count, so a same-cycle pop does not unblock issue.
- Pointers wrap modulo DEPTH.
- Orphan: dp_out_valid while FIFO empty -> no resp pulse, FIFO untouched, orphan_err<=1 until reset.
- Reset mid-operation clears all in-flight tags. The datapath shares rst_n, so no stale results are expected.

Optional Feature:
- Macro LAB08_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0, grant_cnt1 (16-bit each). Each increments on its requester's handshake, saturates at 16'hFFFF, and resets to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package lab08_arb_pkg:
  - DW_IN/DW_OUT defaults.
  - typedef req_id_t (1-bit logic).
  - Localparam REQ0=1'b0, REQ1=1'b1.
- Sub-module lab08_tag_fifo:
  - Parameterised DEPTH, req_id_t entries.
  - push/pop/full/empty/count.
- The arbiter instantiates one lab08_tag_fifo.

Test Plan:
- Reset: rst_n low 2ns mid-cycle -> all outputs 0 immediately (async), inflight=0, orphan_err=0.
- Single requester: req0 sends (3,5) one cycle -> dp_in_valid=1 with data (3,5) next cycle. A model datapath returns 15 three cycles later -> resp0_valid=1, resp0_data=15 one cycle after that; resp1_valid stays 0.
- Contention: both valid for 6 cycles with a model datapath latency 2 -> grant order 0,1,0,1,0,1. Results are routed to the matching resp port in issue order.
- Full: datapath never returns, req0 held valid -> exactly 4 handshakes, then req0_ready=0 with inflight=4. One dp_out_valid -> inflight=3 and one more handshake next cycle.
- Orphan: dp_out_valid=1, data 8'hAA, with FIFO empty -> no resp pulse, orphan_err=1 held until rst_n.
- LAB08_ARB_STATS_EN: 300 req1 handshakes -> grant_cnt1=300, grant_cnt0=0.

Source files
------------

// File: rtl/lab08_dp_arbiter_pkg.sv
// Shared types and defaults for the Lab08 two-requester datapath arbiter.
package lab08_arb_pkg;

  localparam int DW_IN_DEFAULT  = 3;
  localparam int DW_OUT_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 4;

  // Requester identity carried through the tag FIFO.
  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/lab08_dp_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared datapath.
//
// Request handshake: a transfer happens on a rising clk edge where
// reqN_valid && reqN_ready. The requester holds valid/data stable until it
// sees ready; ready is combinational from the valids, the last grant and the
// in-flight count only. Datapath and response sides are valid-only pulses
// with no backpressure.
//
// slave  : the arbiter's view.
// master : the environment's view (requesters + datapath).
interface lab08_dp_arbiter_if
  import lab08_arb_pkg::*;
#(
  parameter int DW_IN  = DW_IN_DEFAULT,
  parameter int DW_OUT = DW_OUT_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              req0_valid;
  logic              req0_ready;
  logic [DW_IN-1:0]  req0_data1;
  logic [DW_IN-1:0]  req0_data2;
  logic              req1_valid;
  logic              req1_ready;
  logic [DW_IN-1:0]  req1_data1;
  logic [DW_IN-1:0]  req1_data2;
  logic              dp_in_valid;
  logic [DW_IN-1:0]  dp_in_data1;
  logic [DW_IN-1:0]  dp_in_data2;
  logic              dp_out_valid;
  logic [DW_OUT-1:0] dp_out_data;
  logic              resp0_valid;
  logic [DW_OUT-1:0] resp0_data;
  logic              resp1_valid;
  logic [DW_OUT-1:0] resp1_data;
  logic [CW-1:0]     inflight;
  logic              orphan_err;

  modport slave (
    input  req0_valid, req0_data1, req0_data2,
    input  req1_valid, req1_data1, req1_data2,
    input  dp_out_valid, dp_out_data,
    output req0_ready, req1_ready,
    output dp_in_valid, dp_in_data1, dp_in_data2,
    output resp0_valid, resp0_data, resp1_valid, resp1_data,
    output inflight, orphan_err
  );

  modport master (
    output req0_valid, req0_data1, req0_data2,
    output req1_valid, req1_data1, req1_data2,
    output dp_out_valid, dp_out_data,
    input  req0_ready, req1_ready,
    input  dp_in_valid, dp_in_data1, dp_in_data2,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data,
    input  inflight, orphan_err
  );

endinterface

// File: rtl/lab08_dp_arbiter_tag_fifo.sv
// Tag FIFO: remembers which requester owns each in-flight datapath operation.
// Pushes while full and pops while empty are ignored.
module lab08_tag_fifo
  import lab08_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  req_id_t       i_push_id,
  input  logic          i_pop,
  output req_id_t       o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  req_id_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= REQ0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lab08_dp_arbiter.sv
// Round-robin arbiter sharing one in-order, non-stalling datapath between two
// requesters. Issues at most one operand pair per cycle, tags it with the
// requester ID and steers each returned result back to its owner.
// Optional build macro LAB08_ARB_STATS_EN adds saturating 16-bit grant counters.
module lab08_dp_arbiter
  import lab08_arb_pkg::*;
#(
  parameter int DW_IN  = DW_IN_DEFAULT,
  parameter int DW_OUT = DW_OUT_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef LAB08_ARB_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  lab08_dp_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              w_full;
  logic              w_empty;
  logic              w_req0_ready;
  logic              w_req1_ready;
  logic              w_hs0;
  logic              w_hs1;
  logic              w_push;
  logic              w_pop;
  req_id_t           w_push_id;
  req_id_t           w_head_id;
  logic [CW-1:0]     w_count;

  req_id_t           r_last_grant;
  logic              r_dp_in_valid;
  logic [DW_IN-1:0]  r_dp_in_data1;
  logic [DW_IN-1:0]  r_dp_in_data2;
  logic              r_resp0_valid;
  logic              r_resp1_valid;
  logic [DW_OUT-1:0] r_resp0_data;
  logic [DW_OUT-1:0] r_resp1_data;
  logic              r_orphan_err;

  // Grant: a lone requester wins, contention goes to whoever was not granted last.
  always_comb begin
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    if (!w_full) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_req0_ready = (r_last_grant == REQ1);
        w_req1_ready = (r_last_grant == REQ0);
      end else begin
        w_req0_ready = bus.req0_valid;
        w_req1_ready = bus.req1_valid;
      end
    end
  end

  assign w_hs0     = bus.req0_valid & w_req0_ready;
  assign w_hs1     = bus.req1_valid & w_req1_ready;
  assign w_push    = w_hs0 | w_hs1;
  assign w_push_id = w_hs1 ? REQ1 : REQ0;
  // A return with nothing outstanding is an orphan and must not disturb the FIFO.
  assign w_pop     = bus.dp_out_valid & ~w_empty;

  lab08_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_push_id (w_push_id),
    .i_pop     (w_pop),
    .o_head    (w_head_id),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Issue stage: register the granted operand pair, zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_in_valid <= 1'b0;
      r_dp_in_data1 <= '0;
      r_dp_in_data2 <= '0;
      r_last_grant  <= REQ1;
    end else begin
      r_dp_in_valid <= w_push;
      if (w_hs0) begin
        r_dp_in_data1 <= bus.req0_data1;
        r_dp_in_data2 <= bus.req0_data2;
      end else if (w_hs1) begin
        r_dp_in_data1 <= bus.req1_data1;
        r_dp_in_data2 <= bus.req1_data2;
      end else begin
        r_dp_in_data1 <= '0;
        r_dp_in_data2 <= '0;
      end
      if (w_push) r_last_grant <= w_push_id;
    end
  end

  // Return stage: steer the result to the owner at the FIFO head; sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp1_data  <= '0;
      r_orphan_err  <= 1'b0;
    end else begin
      r_resp0_valid <= w_pop & (w_head_id == REQ0);
      r_resp1_valid <= w_pop & (w_head_id == REQ1);
      r_resp0_data  <= (w_pop && (w_head_id == REQ0)) ? bus.dp_out_data : '0;
      r_resp1_data  <= (w_pop && (w_head_id == REQ1)) ? bus.dp_out_data : '0;
      if (bus.dp_out_valid && w_empty) r_orphan_err <= 1'b1;
    end
  end

`ifdef LAB08_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  // Per-requester handshake counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (w_hs0 && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_hs1 && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`else
  // No statistics in this build.
`endif

  assign bus.req0_ready  = w_req0_ready;
  assign bus.req1_ready  = w_req1_ready;
  assign bus.dp_in_valid = r_dp_in_valid;
  assign bus.dp_in_data1 = r_dp_in_data1;
  assign bus.dp_in_data2 = r_dp_in_data2;
  assign bus.resp0_valid = r_resp0_valid;
  assign bus.resp0_data  = r_resp0_data;
  assign bus.resp1_valid = r_resp1_valid;
  assign bus.resp1_data  = r_resp1_data;
  assign bus.inflight    = w_count;
  assign bus.orphan_err  = r_orphan_err;

endmodule

// File: tb/tb_lab08_dp_arbiter.sv
// Self-checking bench for lab08_dp_arbiter: grant vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference.
// Build with LAB08_ARB_STATS_EN to also exercise the grant counters.
module tb_lab08_dp_arbiter;
  import lab08_arb_pkg::*;

  localparam int DW_IN  = 3;
  localparam int DW_OUT = 8;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lab08_dp_arbiter_if #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .DEPTH(DEPTH)) bus ();

`ifdef LAB08_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  lab08_dp_arbiter #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef LAB08_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- datapath model: fixed latency, result = a*b ----------------
  typedef struct { logic v; logic [DW_OUT-1:0] d; } dp_ent_t;
  dp_ent_t dp_pipe[$];
  bit      dp_en;

  task automatic dp_step();
    dp_ent_t e, n;
    if (dp_en) begin
      e = dp_pipe.pop_front();
      bus.dp_out_valid = e.v;
      bus.dp_out_data  = e.d;
      n.v = bus.dp_in_valid;
      n.d = DW_OUT'(bus.dp_in_data1) * DW_OUT'(bus.dp_in_data2);
      dp_pipe.push_back(n);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    dp_step();
  endtask

  function automatic logic [DW_IN-1:0] rnd();
    return DW_IN'($urandom_range(0, (1 << DW_IN) - 1));
  endfunction

  // ---------------- reference model / scoreboard ----------------
  req_id_t           m_tags[$];
  logic [DW_OUT-1:0] exp_q0[$];
  logic [DW_OUT-1:0] exp_q1[$];
  req_id_t           m_lg;
  logic              m_dpv, m_rv0, m_rv1, m_orph;
  logic [DW_IN-1:0]  m_d1, m_d2;
  logic [DW_OUT-1:0] m_rd0, m_rd1;
  bit                grant_log[$];

  task automatic check_idle_outputs(input string tag);
    chk({tag, " dp_in_valid"}, bus.dp_in_valid, 0);
    chk({tag, " dp_in_data1"}, bus.dp_in_data1, 0);
    chk({tag, " dp_in_data2"}, bus.dp_in_data2, 0);
    chk({tag, " resp0_valid"}, bus.resp0_valid, 0);
    chk({tag, " resp1_valid"}, bus.resp1_valid, 0);
    chk({tag, " resp0_data"},  bus.resp0_data, 0);
    chk({tag, " resp1_data"},  bus.resp1_data, 0);
    chk({tag, " inflight"},    bus.inflight, 0);
    chk({tag, " orphan_err"},  bus.orphan_err, 0);
  endtask

  // lat = 0 leaves dp_out under manual control.
  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_data1 = 0; bus.req0_data2 = 0;
    bus.req1_valid = 0; bus.req1_data1 = 0; bus.req1_data2 = 0;
    bus.dp_out_valid = 0; bus.dp_out_data = 0;
    dp_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    m_tags.delete(); exp_q0.delete(); exp_q1.delete();
    m_lg = REQ1;
    m_dpv = 0; m_rv0 = 0; m_rv1 = 0; m_orph = 0;
    m_d1 = 0; m_d2 = 0; m_rd0 = 0; m_rd1 = 0;
    dp_pipe.delete();
    for (int i = 0; i < lat; i++) dp_pipe.push_back('{1'b0, '0});
    dp_en = (lat > 0);
  endtask

  // One cycle of traffic: drive, compare against the model at negedge, advance model, clock.
  task automatic run_cycle(input logic v0, input logic v1,
                           input logic [DW_IN-1:0] a0, input logic [DW_IN-1:0] b0,
                           input logic [DW_IN-1:0] a1, input logic [DW_IN-1:0] b1);
    bit e_r0, e_r1, hs0, hs1;
    req_id_t id;
    bus.req0_valid = v0; bus.req0_data1 = a0; bus.req0_data2 = b0;
    bus.req1_valid = v1; bus.req1_data1 = a1; bus.req1_data2 = b1;
    @(negedge clk);
    chk("dp_in_valid", bus.dp_in_valid, m_dpv);
    chk("dp_in_data1", bus.dp_in_data1, m_d1);
    chk("dp_in_data2", bus.dp_in_data2, m_d2);
    chk("resp0_valid", bus.resp0_valid, m_rv0);
    chk("resp0_data",  bus.resp0_data,  m_rd0);
    chk("resp1_valid", bus.resp1_valid, m_rv1);
    chk("resp1_data",  bus.resp1_data,  m_rd1);
    chk("inflight",    bus.inflight,    m_tags.size());
    chk("orphan_err",  bus.orphan_err,  m_orph);
    e_r0 = 0; e_r1 = 0;
    if (m_tags.size() < DEPTH) begin
      if (v0 && v1) begin
        e_r0 = (m_lg == REQ1);
        e_r1 = (m_lg == REQ0);
      end else begin
        e_r0 = v0;
        e_r1 = v1;
      end
    end
    chk("req0_ready", bus.req0_ready, e_r0);
    chk("req1_ready", bus.req1_ready, e_r1);
    if (bus.req0_ready) grant_log.push_back(1'b0);
    else if (bus.req1_ready) grant_log.push_back(1'b1);
    // returns pop the oldest outstanding tag before this cycle's issue is added
    m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
    if (bus.dp_out_valid) begin
      if (m_tags.size() == 0) m_orph = 1;
      else begin
        id = m_tags.pop_front();
        if (id == REQ0) begin m_rv0 = 1; if (exp_q0.size() > 0) m_rd0 = exp_q0.pop_front(); end
        else            begin m_rv1 = 1; if (exp_q1.size() > 0) m_rd1 = exp_q1.pop_front(); end
      end
    end
    hs0 = v0 && e_r0;
    hs1 = v1 && e_r1;
    m_dpv = hs0 || hs1;
    m_d1 = hs0 ? a0 : (hs1 ? a1 : '0);
    m_d2 = hs0 ? b0 : (hs1 ? b1 : '0);
    if (hs0) begin m_tags.push_back(REQ0); exp_q0.push_back(DW_OUT'(a0) * DW_OUT'(b0)); m_lg = REQ0; end
    if (hs1) begin m_tags.push_back(REQ1); exp_q1.push_back(DW_OUT'(a1) * DW_OUT'(b1)); m_lg = REQ1; end
    next_cycle();
  endtask

  // ---------------- grant / full vector table ----------------
  typedef struct {
    bit v0, v1, dpo;
    int infl;
    bit r0, r1, dpv, rv0, rv1;
  } vec_t;
  vec_t vt[9];

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // v0 v1 dpo | inflight r0 r1 dp_in_valid resp0_valid resp1_valid (datapath never returns unless dpo)
    vt[0] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    vt[1] = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    vt[2] = '{0, 1, 0, 2, 0, 1, 1, 0, 0};
    vt[3] = '{1, 1, 0, 3, 1, 0, 1, 0, 0};
    vt[4] = '{1, 1, 0, 4, 0, 0, 1, 0, 0};
    vt[5] = '{0, 1, 1, 4, 0, 0, 0, 0, 0};
    vt[6] = '{0, 1, 0, 3, 0, 1, 0, 1, 0};
    vt[7] = '{1, 1, 1, 4, 0, 0, 1, 0, 0};
    vt[8] = '{0, 0, 0, 3, 0, 0, 0, 0, 1};

    // ---- table: alternation, full blocking, same-cycle pop does not unblock ----
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      bus.req0_valid = vt[i].v0; bus.req0_data1 = 3'd1; bus.req0_data2 = 3'd2;
      bus.req1_valid = vt[i].v1; bus.req1_data1 = 3'd4; bus.req1_data2 = 3'd5;
      bus.dp_out_valid = vt[i].dpo; bus.dp_out_data = 8'h5A;
      @(negedge clk);
      chk($sformatf("vec%0d inflight", i),    bus.inflight,    vt[i].infl);
      chk($sformatf("vec%0d req0_ready", i),  bus.req0_ready,  vt[i].r0);
      chk($sformatf("vec%0d req1_ready", i),  bus.req1_ready,  vt[i].r1);
      chk($sformatf("vec%0d dp_in_valid", i), bus.dp_in_valid, vt[i].dpv);
      chk($sformatf("vec%0d resp0_valid", i), bus.resp0_valid, vt[i].rv0);
      chk($sformatf("vec%0d resp1_valid", i), bus.resp1_valid, vt[i].rv1);
      chk($sformatf("vec%0d resp0_data", i),  bus.resp0_data,  vt[i].rv0 ? 8'h5A : 8'h00);
      chk($sformatf("vec%0d resp1_data", i),  bus.resp1_data,  vt[i].rv1 ? 8'h5A : 8'h00);
      @(posedge clk);
      #1;
    end

    // ---- single requester: (3,5) with datapath latency 3 ----
    do_reset(3);
    run_cycle(1, 0, 3'd3, 3'd5, 3'd0, 3'd0);
    chk("single dp_in_valid", bus.dp_in_valid, 1);
    chk("single dp_in_data1", bus.dp_in_data1, 3);
    chk("single dp_in_data2", bus.dp_in_data2, 5);
    for (int c = 2; c <= 5; c++) begin
      run_cycle(0, 0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk($sformatf("single resp0_valid c%0d", c), bus.resp0_valid, (c == 5));
      chk($sformatf("single resp1_valid c%0d", c), bus.resp1_valid, 0);
      if (c == 5) chk("single resp0_data", bus.resp0_data, 15);
    end

    // ---- contention: both valid 6 cycles, latency 2 ----
    do_reset(2);
    grant_log.delete();
    repeat (6) run_cycle(1, 1, rnd(), rnd(), rnd(), rnd());
    chk("contention grant count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("contention grant%0d", i), grant_log[i], i % 2);
    repeat (6) run_cycle(0, 0, 3'd0, 3'd0, 3'd0, 3'd0);

    // ---- orphan return, then asynchronous reset mid-cycle ----
    do_reset(0);
    bus.dp_out_valid = 1; bus.dp_out_data = 8'hAA;
    @(posedge clk);
    #1;
    bus.dp_out_valid = 0; bus.dp_out_data = 0;
    chk("orphan resp0_valid", bus.resp0_valid, 0);
    chk("orphan resp1_valid", bus.resp1_valid, 0);
    chk("orphan resp0_data",  bus.resp0_data, 0);
    chk("orphan inflight",    bus.inflight, 0);
    chk("orphan flag",        bus.orphan_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("orphan sticky", bus.orphan_err, 1);
    bus.req0_valid = 1; bus.req0_data1 = 3'd3; bus.req0_data2 = 3'd5;
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    chk("pre-reset dp_in_valid", bus.dp_in_valid, 1);
    chk("pre-reset inflight",    bus.inflight, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    #1 rst_n = 1'b1;

    // ---- randomized traffic against the reference model ----
    foreach (dp_pipe[i]) dp_pipe[i] = '{1'b0, '0};
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(seg == 0 ? 1 : (seg == 1 ? 2 : (seg == 2 ? 4 : 6)));
      repeat (150)
        run_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  rnd(), rnd(), rnd(), rnd());
      repeat (8) run_cycle(0, 0, 3'd0, 3'd0, 3'd0, 3'd0);
    end

`ifdef LAB08_ARB_STATS_EN
    // ---- grant counters: 300 requester-1 handshakes ----
    do_reset(1);
    chk("stats reset cnt0", grant_cnt0, 0);
    chk("stats reset cnt1", grant_cnt1, 0);
    repeat (300) run_cycle(0, 1, 3'd0, 3'd0, rnd(), rnd());
    chk("stats grant_cnt1", grant_cnt1, 300);
    chk("stats grant_cnt0", grant_cnt0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
